// File: rtl/ahb_slave_memory_pkg.sv
// -----------------------------------------------------------------------------
// AhbGlobalPackage
// Shared constants and types for the AHB slave memory:
//   - default bus/memory geometry (ADDR_WIDTH, DATA_WIDTH, SLAVE_MEMORY_SIZE)
//   - htrans and hresp encodings
//   - FSM state typedef (ERR1/ERR2 exist only with AHB_SLAVE_MEMORY_ERROR_RESP_EN)
//   - size_lane_mask(): byte lanes touched by a transfer of a given size/offset
// -----------------------------------------------------------------------------
package AhbGlobalPackage;

  localparam int ADDR_WIDTH        = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int SLAVE_MEMORY_SIZE = 10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

`ifdef AHB_SLAVE_MEMORY_ERROR_RESP_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } ahb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } ahb_state_e;
`endif

  // Lanes covered by a (1 << size)-byte transfer starting at byte 'offset'.
  // 'offset' must already be aligned to the size.
  function automatic logic [7:0] size_lane_mask(input logic [1:0] size,
                                                input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// -----------------------------------------------------------------------------
// ahb_slave_mem_array
// Word-organised byte-lane storage: one synchronous byte-enable write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk_i    clock (write on rising edge)
//   we_i     write enable
//   waddr_i  write word address
//   be_i     byte-lane enables for the write
//   wdata_i  write data
//   raddr_i  read word address
//   rdata_o  read data (combinational)
// -----------------------------------------------------------------------------
module ahb_slave_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_AW    = 8
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [WORD_AW-1:0]      waddr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [WORD_AW-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [2**WORD_AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_memory.sv
// -----------------------------------------------------------------------------
// ahb_slave_memory
// AHB slave backed by a 2**SLAVE_MEMORY_SIZE byte memory with optional wait
// states. Write data lands on the edge that completes its data phase; a read
// whose address phase coincides with that edge sees the merged new data.
//
// Build option: AHB_SLAVE_MEMORY_ERROR_RESP_EN
//   defined   - misaligned, oversize or out-of-range transfers get a two-cycle
//               ERROR response (ERR1, ERR2) and no memory access.
//   undefined - every transfer is OKAY; address wraps, is aligned down, and
//               oversize hsize acts as full bus width.
//
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   hselx, haddr, htrans   address phase select / address / transfer type
//   hwrite, hsize, hwstrb  direction, size, byte strobes (address phase)
//   hburst, hprot, hmastlock  accepted, unused
//   hwdata                 write data (data phase)
//   hready                 bus ready in
//   hreadyout, hresp, hrdata  data phase response
//
// Handshake: an address phase is taken on a rising edge where hselx=1,
// hready=1 and htrans is NONSEQ/SEQ; its data phase completes on the first
// later edge with hreadyout=1, and hrdata/hresp are valid in that cycle.
// -----------------------------------------------------------------------------
module ahb_slave_memory #(
  parameter int DATA_WIDTH        = AhbGlobalPackage::DATA_WIDTH,
  parameter int ADDR_WIDTH        = AhbGlobalPackage::ADDR_WIDTH,
  parameter int SLAVE_MEMORY_SIZE = AhbGlobalPackage::SLAVE_MEMORY_SIZE,
  parameter int WAIT_STATES       = 0
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic                    hmastlock,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [1:0]              hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  import AhbGlobalPackage::*;

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         OFFW     = $clog2(NB);
  localparam int         WORD_AW  = SLAVE_MEMORY_SIZE - OFFW;
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  ahb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic                  pend_q;     // OKAY data phase outstanding
  logic                  write_q;
  logic [WORD_AW-1:0]    word_q;
  logic [NB-1:0]         lane_q;
  logic [NB-1:0]         strb_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  // Address-phase decode
  logic                  accept;
  logic [2:0]            eff_size;
  logic [OFFW-1:0]       align_mask;
  logic [OFFW-1:0]       offset;
  logic [NB-1:0]         lane_mask;
  logic [WORD_AW-1:0]    word_addr;

  // hreadyout_q is high only in IDLE/ERR2, the states that can take a new
  // address phase.
  assign accept     = hselx && hready && htrans[1] && hreadyout_q;
  assign eff_size   = (hsize > MAX_SIZE) ? MAX_SIZE : hsize;
  assign align_mask = OFFW'((32'd1 << eff_size) - 32'd1);
  assign offset     = haddr[OFFW-1:0] & ~align_mask;
  assign lane_mask  = NB'(size_lane_mask(eff_size[1:0], 3'(offset)));
  assign word_addr  = haddr[SLAVE_MEMORY_SIZE-1:OFFW];

`ifdef AHB_SLAVE_MEMORY_ERROR_RESP_EN
  logic addr_err;
  assign addr_err = (hsize > MAX_SIZE)
                 || ((haddr[OFFW-1:0] & align_mask) != '0)
                 || ((haddr >> SLAVE_MEMORY_SIZE) != '0);
`endif

  // Memory access
  logic                  mem_we;
  logic [NB-1:0]         mem_be;
  logic [WORD_AW-1:0]    rd_word;
  logic [NB-1:0]         rd_lanes;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_data;

  // A pending OKAY transfer completes in an IDLE cycle (hreadyout=1).
  assign mem_we = pend_q && (state_q == IDLE) && write_q;
  assign mem_be = strb_q & lane_q;

  // Zero-wait reads sample at their address phase; waited reads sample from
  // the registered address when the last wait cycle ends.
  assign rd_word  = (state_q == WAIT) ? word_q : word_addr;
  assign rd_lanes = (state_q == WAIT) ? lane_q : lane_mask;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (rd_lanes[i]) begin
        if (mem_we && (word_q == rd_word) && mem_be[i]) rd_data[i*8 +: 8] = hwdata[i*8 +: 8];
        else                                             rd_data[i*8 +: 8] = mem_rdata[i*8 +: 8];
      end
    end
  end

  ahb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_AW    (WORD_AW)
  ) u_mem (
    .clk_i   (hclk),
    .we_i    (mem_we),
    .waddr_i (word_q),
    .be_i    (mem_be),
    .wdata_i (hwdata),
    .raddr_i (rd_word),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      word_q      <= '0;
      lane_q      <= '0;
      strb_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            if (!write_q) hrdata_q <= rd_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef AHB_SLAVE_MEMORY_ERROR_RESP_EN
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
        end
`endif
        default: begin
          // IDLE or ERR2: the current data phase (if any) completes now.
          state_q     <= IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          pend_q      <= 1'b0;
          if (accept) begin
            write_q <= hwrite;
            word_q  <= word_addr;
            lane_q  <= lane_mask;
            strb_q  <= hwstrb;
`ifdef AHB_SLAVE_MEMORY_ERROR_RESP_EN
            if (addr_err) begin
              state_q     <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else
`endif
            if (WAIT_STATES == 0) begin
              pend_q <= 1'b1;
              if (!hwrite) hrdata_q <= rd_data;
            end else begin
              pend_q      <= 1'b1;
              state_q     <= WAIT;
              hreadyout_q <= 1'b0;
              cnt_q       <= 4'(WAIT_STATES - 1);
            end
          end
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], haddr};

endmodule

// File: tb/tb_ahb_slave_memory.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_memory
// Two slave instances share the address/data bus: dut_ws0 (WAIT_STATES=0) and
// dut_ws3 (WAIT_STATES=3); 'tgt' selects which one hselx and hready belong to.
// The driver pushes {waits, hresp, hrdata} into exp_q when an address phase is
// accepted; the monitor pops on every completing data phase.
// -----------------------------------------------------------------------------
module tb_ahb_slave_memory;

  localparam int EW = 38;  // {waits[3:0], hresp[1:0], hrdata[31:0]}

  // clock / reset
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  // bus
  logic        tgt = 1'b0;
  logic        hselx = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = 4'h0;

  logic        sel0, sel3;
  logic        ro0, ro3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rd0, rd3;
  logic        bus_hready;
  logic [1:0]  bus_hresp;
  logic [31:0] bus_hrdata;

  assign sel0       = hselx & ~tgt;
  assign sel3       = hselx & tgt;
  assign bus_hready = tgt ? ro3 : ro0;
  assign bus_hresp  = tgt ? resp3 : resp0;
  assign bus_hrdata = tgt ? rd3 : rd0;

  ahb_slave_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SLAVE_MEMORY_SIZE(10), .WAIT_STATES(0)) dut_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(sel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(bus_hready),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_slave_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SLAVE_MEMORY_SIZE(10), .WAIT_STATES(3)) dut_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hselx(sel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(bus_hready),
    .hreadyout(ro3), .hresp(resp3), .hrdata(rd3)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor
  logic          acc_prev = 1'b0;
  logic          pend = 1'b0;
  int            waits = 0;
  logic [EW-1:0] e;

  always @(negedge hclk) begin
    if (!hresetn) begin
      acc_prev = 1'b0;
      pend     = 1'b0;
    end else begin
      if (acc_prev) begin
        pend  = 1'b1;
        waits = 0;
      end
      if (pend) begin
        if (bus_hready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: unexpected completion, hrdata %h", bus_hrdata);
          end else begin
            e = exp_q.pop_front();
            check("wait_cycles", 32'(waits), 32'(e[37:34]));
            check("hresp", 32'(bus_hresp), 32'(e[33:32]));
            check("hrdata", bus_hrdata, e[31:0]);
          end
          pend = 1'b0;
        end else begin
          waits++;
          if (exp_q.size() != 0 && exp_q[0][33:32] == 2'b01)
            check("err1_hresp", 32'(bus_hresp), 32'h1);
        end
      end
      acc_prev = hselx & bus_hready & htrans[1];
    end
  end

  // driver
  logic [31:0]   s_addr[16];
  logic          s_wr[16];
  logic [2:0]    s_size[16];
  logic [3:0]    s_strb[16];
  logic [31:0]   s_wdata[16];
  logic [EW-1:0] s_exp[16];
  int            s_n = 0;

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [3:0] st, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic [1:0] exp_r, input logic [3:0] exp_w);
    s_addr[s_n]  = a;
    s_wr[s_n]    = w;
    s_size[s_n]  = sz;
    s_strb[s_n]  = st;
    s_wdata[s_n] = wd;
    s_exp[s_n]   = {exp_w, exp_r, exp_d};
    s_n++;
  endtask

  task automatic drive_addr(input int i);
    hselx  = 1'b1;
    haddr  = s_addr[i];
    htrans = 2'b10;
    hwrite = s_wr[i];
    hsize  = s_size[i];
    hwstrb = s_strb[i];
  endtask

  task automatic drive_idle();
    hselx  = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwstrb = 4'h0;
  endtask

  // Runs the queued transfers back to back (pipelined) on the selected slave.
  task automatic run_seq(input logic t);
    int   idx;
    bit   open;
    int   budget;
    logic rdy;
    idx = 0;
    open = 1'b0;
    budget = 200;
    @(posedge hclk); #1;
    tgt = t;
    drive_addr(0);
    while (idx < s_n || open) begin
      @(negedge hclk);
      rdy = bus_hready;
      @(posedge hclk); #1;
      if (rdy) begin
        open = 1'b0;
        if (idx < s_n) begin
          exp_q.push_back(s_exp[idx]);
          hwdata = s_wr[idx] ? s_wdata[idx] : 32'h0;
          open = 1'b1;
          idx++;
          if (idx < s_n) drive_addr(idx);
          else drive_idle();
        end
      end
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL seq_timeout: %0d of %0d transfers issued", idx, s_n);
        break;
      end
    end
    drive_idle();
    s_n = 0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge hclk);
    check("rst_hreadyout_ws0", 32'(ro0), 32'h1);
    check("rst_hresp_ws0", 32'(resp0), 32'h0);
    check("rst_hrdata_ws0", rd0, 32'h0);
    check("rst_hreadyout_ws3", 32'(ro3), 32'h1);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    // write then read same word, read forwarded from the completing write
    add(32'h10, 1, 2, 4'hF, 32'hDEADBEEF, 32'h0, 2'b00, 4'd0);
    add(32'h10, 0, 2, 4'hF, 32'h0, 32'hDEADBEEF, 2'b00, 4'd0);
    run_seq(1'b0);

    // byte write into lane 3 of an existing word
    add(32'h10, 1, 2, 4'hF, 32'h11223344, 32'hDEADBEEF, 2'b00, 4'd0);
    add(32'h13, 1, 0, 4'h8, 32'hAA000000, 32'hDEADBEEF, 2'b00, 4'd0);
    add(32'h10, 0, 2, 4'hF, 32'h0, 32'hAA223344, 2'b00, 4'd0);
    run_seq(1'b0);

    // strobes combined with size lane mask; narrow reads zero other lanes
    add(32'h20, 1, 2, 4'hF, 32'h00000000, 32'hAA223344, 2'b00, 4'd0);
    add(32'h20, 1, 2, 4'h5, 32'hCAFEF00D, 32'hAA223344, 2'b00, 4'd0);
    add(32'h22, 1, 1, 4'hF, 32'h55667788, 32'hAA223344, 2'b00, 4'd0);
    add(32'h20, 0, 2, 4'hF, 32'h0, 32'h5566000D, 2'b00, 4'd0);
    add(32'h22, 0, 1, 4'hF, 32'h0, 32'h55660000, 2'b00, 4'd0);
    add(32'h20, 0, 0, 4'hF, 32'h0, 32'h0000000D, 2'b00, 4'd0);
    run_seq(1'b0);

    // BUSY cycle with a write-like address phase: no access, ready stays high
    @(posedge hclk); #1;
    tgt = 1'b0; hselx = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwstrb = 4'hF;
    @(posedge hclk); #1;
    hwdata = 32'h0; drive_idle();
    @(negedge hclk);
    check("busy_hreadyout", 32'(ro0), 32'h1);
    check("busy_hresp", 32'(resp0), 32'h0);

    // four back-to-back reads, zero wait
    add(32'h10, 0, 2, 4'hF, 32'h0, 32'hAA223344, 2'b00, 4'd0);
    add(32'h20, 0, 2, 4'hF, 32'h0, 32'h5566000D, 2'b00, 4'd0);
    add(32'h23, 0, 0, 4'hF, 32'h0, 32'h55000000, 2'b00, 4'd0);
    add(32'h10, 0, 1, 4'hF, 32'h0, 32'h00003344, 2'b00, 4'd0);
    run_seq(1'b0);

`ifdef AHB_SLAVE_MEMORY_ERROR_RESP_EN
    // misaligned, out-of-range and oversize transfers; memory untouched
    add(32'h002, 0, 2, 4'hF, 32'h0, 32'h00003344, 2'b01, 4'd1);
    add(32'h012, 1, 2, 4'hF, 32'hFFFFFFFF, 32'h00003344, 2'b01, 4'd1);
    add(32'h400, 0, 2, 4'hF, 32'h0, 32'h00003344, 2'b01, 4'd1);
    add(32'h010, 0, 3, 4'hF, 32'h0, 32'h00003344, 2'b01, 4'd1);
    add(32'h010, 0, 2, 4'hF, 32'h0, 32'hAA223344, 2'b00, 4'd0);
    run_seq(1'b0);
`else
    // address wrap + align-down, oversize size treated as full width
    add(32'h412, 1, 2, 4'hF, 32'h99887766, 32'h00003344, 2'b00, 4'd0);
    add(32'h010, 0, 3, 4'hF, 32'h0, 32'h99887766, 2'b00, 4'd0);
    add(32'h022, 0, 2, 4'hF, 32'h0, 32'h5566000D, 2'b00, 4'd0);
    run_seq(1'b0);
`endif

    // three wait states on write and read
    add(32'h04, 1, 2, 4'hF, 32'h0BADF00D, 32'h0, 2'b00, 4'd3);
    add(32'h04, 0, 2, 4'hF, 32'h0, 32'h0BADF00D, 2'b00, 4'd3);
    run_seq(1'b1);

    // reset during the WAIT of a write
    @(posedge hclk); #1;
    tgt = 1'b1; hselx = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h04; hsize = 3'd2; hwstrb = 4'hF;
    @(posedge hclk); #1;
    drive_idle(); hwdata = 32'h12345678;
    @(posedge hclk); #2;
    check("wait_before_reset", 32'(ro3), 32'h0);
    hresetn = 1'b0;
    @(negedge hclk);
    check("midrst_hreadyout", 32'(ro3), 32'h1);
    check("midrst_hresp", 32'(resp3), 32'h0);
    check("midrst_hrdata", rd3, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    hwdata = 32'h0;

    add(32'h04, 0, 2, 4'hF, 32'h0, 32'h0BADF00D, 2'b00, 4'd3);
    run_seq(1'b1);

    repeat (3) @(negedge hclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
